// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a per-entry saturating direction counter.
// Lookup is combinational from pc_IF; resolved outcomes are written back one per cycle.
`timescale 1ns/1ps

module branch_predictor #(
  parameter int ADDR_WIDTH = 64,
  parameter int ENTRIES    = 16,
  parameter int TAG_WIDTH  = 8,
  parameter int CNT_WIDTH  = 2,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_IF,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_mispred,
  input  logic                  inv_all,
  output logic [PERF_WIDTH-1:0] perf_upd,
  output logic [PERF_WIDTH-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + 1 + TAG_WIDTH;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_WT  = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_WNT = CNT_WT - CNT_WIDTH'(1);

  logic                  r_valid  [ENTRIES];
  logic [TAG_WIDTH-1:0]  r_tag    [ENTRIES];
  logic                  r_isJump [ENTRIES];
  logic [CNT_WIDTH-1:0]  r_cnt    [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [ENTRIES];

  logic [PERF_WIDTH-1:0] r_perfUpd;
  logic [PERF_WIDTH-1:0] r_perfMispred;

  logic [IDX_W-1:0]     w_lkIdx;
  logic [TAG_WIDTH-1:0] w_lkTag;
  logic [IDX_W-1:0]     w_updIdx;
  logic [TAG_WIDTH-1:0] w_updTag;
  logic                 w_lkHit;
  logic                 w_updHit;
  logic                 w_unusedBits;

  assign w_lkIdx  = pc_IF[IDX_W+1:2];
  assign w_lkTag  = pc_IF[TAG_HI:TAG_LO];
  assign w_updIdx = upd_pc[IDX_W+1:2];
  assign w_updTag = upd_pc[TAG_HI:TAG_LO];

  // Address bits above the partial tag and the halfword offset never reach the table.
  assign w_unusedBits = ^{pc_IF[ADDR_WIDTH-1:TAG_HI+1], pc_IF[1:0],
                          upd_pc[ADDR_WIDTH-1:TAG_HI+1], upd_pc[1:0]};

  assign w_lkHit  = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
  assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

  assign pred_hit    = w_lkHit;
  assign pred_taken  = w_lkHit && (r_isJump[w_lkIdx] || r_cnt[w_lkIdx][CNT_WIDTH-1]);
  assign pred_target = w_lkHit ? r_target[w_lkIdx] : '0;

  assign perf_upd     = r_perfUpd;
  assign perf_mispred = r_perfMispred;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_WNT;
      end
      r_perfUpd     <= '0;
      r_perfMispred <= '0;
    end else begin
      if (upd_valid) begin
        r_perfUpd <= r_perfUpd + PERF_WIDTH'(1);
        if (upd_mispred) r_perfMispred <= r_perfMispred + PERF_WIDTH'(1);
      end
      // Invalidation wins over a concurrent update, which then leaves the table alone.
      if (inv_all) begin
        for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
      end else if (upd_valid) begin
        if (w_updHit) begin
          if (upd_taken) begin
            if (r_cnt[w_updIdx] != CNT_MAX) r_cnt[w_updIdx] <= r_cnt[w_updIdx] + CNT_WIDTH'(1);
            r_target[w_updIdx] <= upd_target;
          end else if (r_cnt[w_updIdx] != '0) begin
            r_cnt[w_updIdx] <= r_cnt[w_updIdx] - CNT_WIDTH'(1);
          end
          r_isJump[w_updIdx] <= upd_is_jump;
        end else if (upd_taken) begin
          r_valid[w_updIdx]  <= 1'b1;
          r_tag[w_updIdx]    <= w_updTag;
          r_isJump[w_updIdx] <= upd_is_jump;
          r_cnt[w_updIdx]    <= CNT_WT;
          r_target[w_updIdx] <= upd_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: counters, jumps, aliasing, invalidation.
`timescale 1ns/1ps

module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [63:0] pc_IF;
  logic        pred_hit;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        upd_mispred;
  logic        inv_all;
  logic [31:0] perf_upd;
  logic [31:0] perf_mispred;

  int checks = 0;
  int errors = 0;
  int expUpd = 0;
  int expMis = 0;

  branch_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .pc_IF        (pc_IF),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_is_jump  (upd_is_jump),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .upd_mispred  (upd_mispred),
    .inv_all      (inv_all),
    .perf_upd     (perf_upd),
    .perf_mispred (perf_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one update at a falling edge; it is committed at the following rising edge.
  task automatic applyStimulus(input logic [63:0] pc, input logic isJump, input logic taken,
                               input logic [63:0] target, input logic mispred);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_is_jump = isJump;
    upd_taken   = taken;
    upd_target  = target;
    upd_mispred = mispred;
    expUpd++;
    if (mispred) expMis++;
    @(negedge clk);
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
  endtask

  task automatic lookupCheck(input string tag, input logic [63:0] pc, input logic expHit,
                             input logic expTaken, input logic [63:0] expTarget);
    pc_IF = pc;
    #1;
    checkOutput({tag, ".hit"}, 64'(pred_hit), 64'(expHit));
    checkOutput({tag, ".taken"}, 64'(pred_taken), 64'(expTaken));
    checkOutput({tag, ".target"}, pred_target, expTarget);
  endtask

  task automatic perfCheck(input string tag);
    checkOutput({tag, ".perfUpd"}, 64'(perf_upd), 64'(expUpd));
    checkOutput({tag, ".perfMis"}, 64'(perf_mispred), 64'(expMis));
  endtask

  initial begin
    rst = 1'b1;
    pc_IF = 64'h8000_0000;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_is_jump = 1'b0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_mispred = 1'b0;
    inv_all = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    lookupCheck("reset", 64'h8000_0000, 1'b0, 1'b0, 64'h0);
    perfCheck("reset");

    // Taken branch allocates with a weak-taken counter.
    applyStimulus(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100, 1'b1);
    lookupCheck("alloc", 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100);
    perfCheck("alloc");

    // Counter walks 2->1->0->0; a not-taken update leaves the target alone.
    applyStimulus(64'h8000_0010, 1'b0, 1'b0, 64'h8000_0104, 1'b1);
    lookupCheck("nt1", 64'h8000_0010, 1'b1, 1'b0, 64'h8000_0100);
    applyStimulus(64'h8000_0010, 1'b0, 1'b0, 64'h8000_0104, 1'b0);
    applyStimulus(64'h8000_0010, 1'b0, 1'b0, 64'h8000_0104, 1'b0);
    lookupCheck("nt3", 64'h8000_0010, 1'b1, 1'b0, 64'h8000_0100);
    applyStimulus(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0200, 1'b1);
    lookupCheck("satUp1", 64'h8000_0010, 1'b1, 1'b0, 64'h8000_0200);
    applyStimulus(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0200, 1'b0);
    lookupCheck("satUp2", 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0200);
    perfCheck("counter");

    // Jump entries keep predicting taken even when the counter drops.
    applyStimulus(64'h8000_0020, 1'b1, 1'b1, 64'h8000_0400, 1'b0);
    lookupCheck("jump", 64'h8000_0020, 1'b1, 1'b1, 64'h8000_0400);
    applyStimulus(64'h8000_0020, 1'b1, 1'b0, 64'h8000_0404, 1'b1);
    applyStimulus(64'h8000_0020, 1'b1, 1'b0, 64'h8000_0404, 1'b0);
    lookupCheck("jumpNt", 64'h8000_0020, 1'b1, 1'b1, 64'h8000_0400);
    lookupCheck("otherIdx", 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0200);

    // Same-cycle update and lookup: old prediction now, new one after the edge.
    pc_IF = 64'h8000_0010;
    upd_valid = 1'b1;
    upd_pc = 64'h8000_0010;
    upd_is_jump = 1'b0;
    upd_taken = 1'b0;
    upd_target = 64'h0;
    upd_mispred = 1'b0;
    expUpd++;
    #1;
    checkOutput("noBypass.old", 64'(pred_taken), 64'd1);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    checkOutput("noBypass.new", 64'(pred_taken), 64'd0);

    // Invalidate together with an allocating update: table cleared, update still counted.
    inv_all = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 64'h8000_0030;
    upd_is_jump = 1'b0;
    upd_taken = 1'b1;
    upd_target = 64'h8000_0300;
    upd_mispred = 1'b1;
    expUpd++;
    expMis++;
    @(negedge clk);
    inv_all = 1'b0;
    upd_valid = 1'b0;
    upd_mispred = 1'b0;
    lookupCheck("inv10", 64'h8000_0010, 1'b0, 1'b0, 64'h0);
    lookupCheck("inv20", 64'h8000_0020, 1'b0, 1'b0, 64'h0);
    lookupCheck("inv30", 64'h8000_0030, 1'b0, 1'b0, 64'h0);
    perfCheck("inv");

    // Conflicting tags at index 4; a not-taken miss must not disturb the entry.
    applyStimulus(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100, 1'b0);
    applyStimulus(64'h8000_0050, 1'b0, 1'b1, 64'h8000_0500, 1'b0);
    lookupCheck("evicted", 64'h8000_0010, 1'b0, 1'b0, 64'h0);
    lookupCheck("evictor", 64'h8000_0050, 1'b1, 1'b1, 64'h8000_0500);
    applyStimulus(64'h8000_0090, 1'b0, 1'b0, 64'h8000_0900, 1'b1);
    lookupCheck("ntMiss", 64'h8000_0050, 1'b1, 1'b1, 64'h8000_0500);
    lookupCheck("ntMissNoAlloc", 64'h8000_0090, 1'b0, 1'b0, 64'h0);
    lookupCheck("lowBits", 64'h8000_0052, 1'b1, 1'b1, 64'h8000_0500);
    perfCheck("conflict");

    // Reset asserted with an update in flight discards the update.
    rst = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 64'h8000_0060;
    upd_is_jump = 1'b1;
    upd_taken = 1'b1;
    upd_target = 64'h8000_0600;
    upd_mispred = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    upd_valid = 1'b0;
    upd_mispred = 1'b0;
    expUpd = 0;
    expMis = 0;
    lookupCheck("rstDrop", 64'h8000_0060, 1'b0, 1'b0, 64'h0);
    lookupCheck("rstClear", 64'h8000_0050, 1'b0, 1'b0, 64'h0);
    perfCheck("rstMid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
